miss_refill_ctrl: RTL and testbench

MISS_REFILL_CTRL -- requirements
Module: miss_refill_ctrl

---
 rtl/miss_refill_ctrl.sv | 151 +++++++++++++++
 tb/tb_miss_refill_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miss_refill_ctrl.sv
// D-cache write-miss refill controller: optional dirty writeback, line fill, tag update.
// Define DCACHE_WB_EN to build the writeback path (WB state) for write-back caches.
module miss_refill_ctrl #(
  parameter  int INDEX_W    = 6,
  parameter  int LINE_WORDS = 4,
  localparam int OFF_W      = $clog2(LINE_WORDS),
  localparam int TAG_W      = 32 - INDEX_W - OFF_W - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_req,
  input  logic [31:0]       miss_addr,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  output logic [OFF_W-1:0]  line_rd_idx,
  input  logic [31:0]       line_rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              fill_we,
  output logic [OFF_W-1:0]  fill_word_idx,
  output logic [31:0]       fill_data,
  output logic              upd_entry,
  output logic              busy
);

`ifdef DCACHE_WB_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FILL   = 2'd2,
    UPDATE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd2,
    UPDATE = 2'd3
  } state_t;
`endif

  state_t             state, state_n;
  logic [OFF_W-1:0]   cnt, cnt_n;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic               cap;
  logic               last;

`ifdef DCACHE_WB_EN
  logic [TAG_W-1:0]   vtag_q;
  logic               unused_ok;
  assign unused_ok = ^{miss_addr[OFF_W+1:0]};
`else
  logic               unused_ok;
  assign unused_ok = ^{miss_addr[OFF_W+1:0], victim_valid,
                       victim_dirty, victim_tag, line_rd_data};
`endif

  assign last = (cnt == OFF_W'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      tag_q  <= '0;
      idx_q  <= '0;
`ifdef DCACHE_WB_EN
      vtag_q <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (cap) begin
        tag_q  <= miss_addr[31 -: TAG_W];
        idx_q  <= miss_addr[OFF_W+2 +: INDEX_W];
`ifdef DCACHE_WB_EN
        vtag_q <= victim_tag;
`endif
      end
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    cap           = 1'b0;
    line_rd_idx   = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    fill_we       = 1'b0;
    fill_word_idx = '0;
    fill_data     = '0;
    upd_entry     = 1'b0;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss_req) begin
          cap   = 1'b1;
          cnt_n = '0;
`ifdef DCACHE_WB_EN
          state_n = (victim_valid && victim_dirty) ? WB : FILL;
`else
          state_n = FILL;
`endif
        end
      end
`ifdef DCACHE_WB_EN
      WB: begin
        busy        = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        line_rd_idx = cnt;
        mem_addr    = {vtag_q, idx_q, cnt, 2'b00};
        mem_wdata   = line_rd_data;
        if (mem_ack) begin
          cnt_n = cnt + 1'b1;
          if (last) begin
            cnt_n   = '0;
            state_n = FILL;
          end
        end
      end
`endif
      FILL: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag_q, idx_q, cnt, 2'b00};
        if (mem_ack) begin
          fill_we       = 1'b1;
          fill_word_idx = cnt;
          fill_data     = mem_rdata;
          cnt_n         = cnt + 1'b1;
          if (last) state_n = UPDATE;
        end
      end
      UPDATE: begin
        busy      = 1'b1;
        upd_entry = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_miss_refill_ctrl.sv
// Scoreboard bench for miss_refill_ctrl: expected memory beats, fills and
// tag-update cycles are queued at issue time and checked by a monitor.
module tb_miss_refill_ctrl;
  localparam int TAG_W = 22;
`ifdef DCACHE_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             miss_req = 1'b0;
  logic [31:0]      miss_addr = '0;
  logic             victim_valid = 1'b0;
  logic             victim_dirty = 1'b0;
  logic [TAG_W-1:0] victim_tag = '0;
  logic [1:0]       line_rd_idx;
  logic [31:0]      line_rd_data;
  logic             mem_req, mem_we;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic             mem_ack = 1'b0;
  logic             fill_we;
  logic [1:0]       fill_word_idx;
  logic [31:0]      fill_data;
  logic             upd_entry, busy;

  logic [31:0] rbase = 32'hA0;
  int gap = 1;
  int wcnt = 0;
  logic spur = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  miss_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag),
    .line_rd_idx(line_rd_idx), .line_rd_data(line_rd_data),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .fill_we(fill_we), .fill_word_idx(fill_word_idx),
    .fill_data(fill_data),
    .upd_entry(upd_entry), .busy(busy)
  );

  assign line_rd_data = 32'hD0 + 32'(line_rd_idx);
  assign mem_rdata    = rbase + 32'(mem_addr[3:2]);

  always @(posedge clk) cyc <= cyc + 1;

  // memory: ack in the gap-th cycle of each request; idle ack = spur
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wcnt >= gap - 1) begin
        mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = spur;
      wcnt = 0;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;
  typedef struct {
    int          idx;
    logic [31:0] data;
    int          at;
  } fill_t;

  mem_t  mq[$];
  fill_t fq[$];
  int    uq[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected / bound expired", name);
  endtask

  logic        hold_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    mem_t  e;
    fill_t f;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (!(mem_req && mem_we))
        check("rd_idx_zero", 32'(line_rd_idx), 32'h0);
      if (mem_req && hold_prev) begin
        check("addr_held", mem_addr, prev_addr);
        check("we_held", 32'(mem_we), 32'(prev_we));
      end
      hold_prev = mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_we   = mem_we;
      if (mem_req && mem_ack) begin
        if (mq.size() == 0) fail("mem_beat");
        else begin
          e = mq.pop_front();
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", mem_addr, e.addr);
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (fill_we) begin
        check("fill_on_ack", 32'(mem_req && mem_ack && !mem_we), 32'h1);
        if (fq.size() == 0) fail("fill_beat");
        else begin
          f = fq.pop_front();
          check("fill_idx", 32'(fill_word_idx), 32'(f.idx));
          check("fill_data", fill_data, f.data);
          check("fill_cycle", 32'(cyc), 32'(f.at));
        end
      end else begin
        check("fill_idle", {fill_word_idx, fill_data[29:0]}, 32'h0);
      end
      if (upd_entry) begin
        check("upd_no_req", 32'(mem_req), 32'h0);
        if (uq.size() == 0) fail("upd_entry");
        else check("upd_cycle", 32'(cyc), 32'(uq.pop_front()));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_addr"}, mem_addr, 32'h0);
    check({name, "_wdata"}, mem_wdata, 32'h0);
    check({name, "_fdata"}, fill_data, 32'h0);
    check({name, "_ctl"}, 32'({mem_req, mem_we, fill_we, fill_word_idx,
                                upd_entry, busy, line_rd_idx}), 32'h0);
  endtask

  task automatic push_refill(input int t, input logic [31:0] base,
                             input bit wb, input logic [31:0] vbase,
                             input logic [31:0] rb);
    int c = t;
    if (wb)
      for (int i = 0; i < 4; i++) begin
        c += gap;
        mq.push_back('{1'b1, vbase + 32'(4 * i), 32'hD0 + 32'(i)});
      end
    for (int i = 0; i < 4; i++) begin
      c += gap;
      mq.push_back('{1'b0, base + 32'(4 * i), 32'h0});
      fq.push_back('{i, rb + 32'(i), c});
    end
    uq.push_back(c + 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    if (busy) fail("idle_timeout");
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] base,
                       input bit dirty, input logic [TAG_W-1:0] vt,
                       input logic [31:0] vbase, input logic [31:0] rb,
                       output int t);
    wait_idle();
    miss_addr    = a;
    victim_valid = 1'b1;
    victim_dirty = dirty;
    victim_tag   = vt;
    rbase        = rb;
    miss_req     = 1'b1;
    t = cyc;
    push_refill(t, base, dirty && WB_EN, vbase, rb);
  endtask

  task automatic wait_done();
    int k = 0;
    while (uq.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    if (uq.size() != 0) begin
      fail("refill_timeout");
      mq.delete();
      fq.delete();
      uq.delete();
    end
    tick();
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] base,
                     input bit dirty, input logic [TAG_W-1:0] vt,
                     input logic [31:0] vbase, input logic [31:0] rb);
    int t;
    issue(a, base, dirty, vt, vbase, rb, t);
    tick();
    miss_req  = 1'b0;
    miss_addr = 32'hDEAD_BEEF;
    wait_done();
  endtask

  initial begin
    int t;
    int k;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    gap = 1;
    run(32'h0000_1234, 32'h0000_1230, 1'b0, '0, '0, 32'hA0);

    gap = 3;
    spur = 1'b1;
    run(32'h0000_ABC8, 32'h0000_ABC0, !WB_EN, 22'h155, 32'h0,
        32'hB0);
    spur = 1'b0;

`ifdef DCACHE_WB_EN
    gap = 1;
    run(32'h0000_1234, 32'h0000_1230, 1'b1, 22'h6, 32'h0000_1A30,
        32'hC0);
`endif

    gap = 1;
    issue(32'h0000_5550, 32'h0000_5550, 1'b0, '0, '0, 32'hE0, t);
    tick();
    miss_req = 1'b0;
    k = 0;
    while (!(fill_we && fill_word_idx == 2'd1) && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) fail("second_fill_timeout");
    rst_n = 1'b0;
    mq.delete();
    fq.delete();
    uq.delete();
    tick();
    check_zero("midrst");
    rst_n = 1'b1;
    repeat (8) tick();
    run(32'h0000_0FFC, 32'h0000_0FF0, 1'b0, '0, '0, 32'h50);

    issue(32'h0000_2000, 32'h0000_2000, 1'b0, '0, '0, 32'h70, t);
    push_refill(t + 6, 32'h0000_3040, 1'b0, '0, 32'h70);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) miss_addr = 32'h0000_3040;
      else miss_addr = (i % 2 == 1) ? 32'h0000_7770 : 32'h0000_1110;
      if (i == 7) miss_req = 1'b0;
    end
    wait_done();
    repeat (4) tick();
    check("queues_empty", 32'(mq.size() + fq.size() + uq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
